// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the RV32M multiply/divide unit.
//   XLEN / CNT_W : operand width and iteration counter width
//   mdu_op_e     : funct3 encodings of the M-extension ops
//   mdu_state_e  : sequencer states
//   DIV0_QUOT / INT_MIN : special-case result constants
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_operand_prep.sv
// mdu_operand_prep: combinational operand conditioning for the multiply/divide unit.
//   i_op        : funct3 of the M-op
//   i_a / i_b   : raw rs1 / rs2 data
//   o_sign_a/b  : operand is treated as signed and is negative
//   o_abs_a/b   : magnitude of each operand under the op's signedness
//   o_div0      : divide/remainder by zero
//   o_ovf       : signed INT_MIN / -1 overflow (DIV/REM only)
module mdu_operand_prep
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = mdu_pkg::XLEN
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_sign_a,
    output logic            o_sign_b,
    output logic [XLEN-1:0] o_abs_a,
    output logic [XLEN-1:0] o_abs_b,
    output logic            o_div0,
    output logic            o_ovf
);

    mdu_op_e w_op;
    logic    w_signed_a;
    logic    w_signed_b;

    assign w_op = mdu_op_e'(i_op);

    always_comb begin
        w_signed_a = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV)  || (w_op == OP_REM);
        w_signed_b = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);

        o_sign_a = w_signed_a & i_a[XLEN-1];
        o_sign_b = w_signed_b & i_b[XLEN-1];
        o_abs_a  = o_sign_a ? (~i_a + 1'b1) : i_a;
        o_abs_b  = o_sign_b ? (~i_b + 1'b1) : i_b;

        o_div0 = i_op[2] && (i_b == '0);
        o_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                 (i_a == INT_MIN) && (i_b == DIV0_QUOT);
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide), one iteration per clock, XLEN iterations per op.
//   clk/rst            : core clock, asynchronous active-high reset
//   i_start            : decoder flags an M-op; held high while stalled
//   i_op               : funct3
//   i_rs1_data/rs2_data: register file operands, latched on acceptance
//   o_stall            : hold PC / suppress write-back while busy
//   o_done             : single-cycle pulse, o_result valid for write-back
//   o_result           : registered result, holds until the next op completes
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = mdu_pkg::XLEN,
    parameter int unsigned CNT_W = mdu_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    mdu_state_e        r_state;
    mdu_state_e        w_state_next;
    mdu_op_e           r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [CNT_W-1:0]  r_cnt;
    // Multiply: {r_hi, r_lo} is the product, r_lo starts as the multiplier.
    // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;

    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_hi_step;
    logic [XLEN-1:0]   w_lo_step;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    mdu_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .i_op     (i_op),
        .i_a      (i_rs1_data),
        .i_b      (i_rs2_data),
        .o_sign_a (w_sign_a),
        .o_sign_b (w_sign_b),
        .o_abs_a  (w_abs_a),
        .o_abs_b  (w_abs_b),
        .o_div0   (w_div0),
        .o_ovf    (w_ovf)
    );

    assign w_special = w_div0 | w_ovf;

    // i_op[1] separates REM/REMU from DIV/DIVU among the divide ops.
    always_comb begin
        if (w_div0) begin
            w_special_res = i_op[1] ? i_rs1_data : DIV0_QUOT;
        end else begin
            w_special_res = i_op[1] ? '0 : INT_MIN;
        end
    end

    // One iteration of the selected algorithm.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_ge    = w_shift >= {1'b0, r_opnd};
        if (r_op[2]) begin
            // The restored difference is below the divisor, so XLEN bits suffice.
            w_hi_step = w_ge ? (w_shift[XLEN-1:0] - r_opnd) : w_shift[XLEN-1:0];
            w_lo_step = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_hi_step = w_sum[XLEN:1];
            w_lo_step = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Sign correction; sign flags are only ever set for ops that need them.
    always_comb begin
        w_prod = {r_hi, r_lo};
        if (r_sign_a ^ r_sign_b) begin
            w_prod = ~w_prod + 1'b1;
        end
        w_quo = (r_sign_a ^ r_sign_b) ? (~r_lo + 1'b1) : r_lo;
        w_rem = r_sign_a ? (~r_hi + 1'b1) : r_hi;
        unique case (r_op)
            OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_fix_res = w_quo;
            default:                       w_fix_res = w_rem;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_next = w_special ? DONE : CALC;
            CALC:    if (r_cnt == CNT_W'(XLEN - 1)) w_state_next = FIXUP;
            FIXUP:   w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM: outputs; stall is combinational so the accepting cycle already stalls.
    always_comb begin
        o_stall  = ((r_state == IDLE) && i_start) || (r_state == CALC) || (r_state == FIXUP);
        o_done   = (r_state == DONE);
        o_result = r_result;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_op     <= mdu_op_e'(i_op);
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_cnt    <= '0;
                        r_hi     <= '0;
                        r_lo     <= i_op[2] ? w_abs_a : w_abs_b;
                        r_opnd   <= i_op[2] ? w_abs_b : w_abs_a;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_hi  <= w_hi_step;
                    r_lo  <= w_lo_step;
                end
                FIXUP: begin
                    r_result <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed bench for mul_div_unit with a
// cycle-level behavioural model and a per-cycle compare process.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_op       (op),
        .i_rs1_data (rs1),
        .i_rs2_data (rs2),
        .o_stall    (stall),
        .o_done     (done),
        .o_result   (result)
    );

    // Architectural RV32M results from plain wide arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] u;
        logic [63:0] t;
        longint      s;
        u = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: return u[31:0];
            3'd1: begin
                s = longint'($signed(a)) * longint'($signed(b));
                t = s;
                return t[63:32];
            end
            3'd2: begin
                s = longint'($signed(a)) * longint'({32'b0, b});
                t = s;
                return t[63:32];
            end
            3'd3: return u[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                s = longint'($signed(a)) / longint'($signed(b));
                t = s;
                return t[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                s = longint'($signed(a)) % longint'($signed(b));
                t = s;
                return t[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == INT_MIN && b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: idle / busy with an edge countdown / one-cycle done.
    bit          m_busy;
    bit          m_done;
    int          m_rem;
    logic [31:0] m_pend;
    logic [31:0] m_result;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_rem    <= 0;
            m_result <= 32'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend;
            end
        end else if (start) begin
            if (is_special(op, rs1, rs2)) begin
                m_done   <= 1'b1;
                m_result <= ref_result(op, rs1, rs2);
            end else begin
                m_busy <= 1'b1;
                m_rem  <= 33;
                m_pend <= ref_result(op, rs1, rs2);
            end
        end
    end

    always @(negedge clk) begin
        check("cyc stall", {31'b0, stall}, {31'b0, m_busy || (!m_done && start)});
        check("cyc done", {31'b0, done}, {31'b0, m_done});
        check("cyc result", result, m_result);
    end

    // Wait for done (first edge counted is the accepting edge), then retire.
    task automatic wait_done(input string name, input logic [31:0] exp, input int exp_edges,
                             input bit toggle);
        int edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (toggle && !done) begin
                rs1 = $urandom;
                rs2 = $urandom;
                op  = 3'($urandom_range(0, 7));
            end
        end while (!done && edges < 100);
        check({name, " latency"}, 32'(edges), 32'(exp_edges));
        check({name, " result"}, result, exp);
        @(posedge clk);
        #1;
        check({name, " single done"}, {31'b0, done}, 32'd0);
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit toggle);
        start = 1'b1;
        op    = f;
        rs1   = a;
        rs2   = b;
        wait_done(name, exp, is_special(f, a, b) ? 1 : 34, toggle);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return INT_MIN;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        rs1   = 32'd0;
        rs2   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("MUL 7*5", 3'd0, 32'd7, 32'd5, 32'h0000_0023, 1'b0);

        // Reset mid-CALC with start held, then a fresh MUL 3*3.
        start = 1'b1;
        op    = 3'd0;
        rs1   = 32'd7;
        rs2   = 32'd9;
        repeat (11) @(posedge clk);
        #3;
        rst = 1'b1;
        op  = 3'd0;
        rs1 = 32'd3;
        rs2 = 32'd3;
        #2;
        check("mid reset result", result, 32'd0);
        check("mid reset done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        wait_done("MUL 3*3 after reset", 32'd9, 34, 1'b0);

        run_op("MULH", 3'd1, INT_MIN, INT_MIN, 32'h4000_0000, 1'b0);
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("DIVU", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
        run_op("DIVU by 0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("REMU by 0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b0);
        run_op("DIV ovf", 3'd4, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1'b0);
        run_op("REM ovf", 3'd6, INT_MIN, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // Operands scrambled while busy; second op follows straight from IDLE.
        run_op("DIVU toggled", 3'd5, 32'd1000, 32'd7, 32'd142, 1'b1);
        run_op("REMU next", 3'd7, 32'd1000, 32'd7, 32'd6, 1'b0);

        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op("random", f, a, b, ref_result(f, a, b), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
